// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: FSM state encoding, idle line level
// and the baud divisor helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    localparam logic IDLE_LEVEL = 1'b1;

    // Clock cycles per serial bit; integer division truncates toward zero.
    function automatic int calc_clks_per_bit(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter for the UART transmitter: counts 0..CLKS_PER_BIT-1 and pulses
// bit_tick on the last cycle of each bit; clear holds it at zero between frames.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic bit_tick
);

    localparam int              CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign bit_tick = !clear && (cnt == CNT_LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 8N1 frames, LSB first, idle-high line, registered tx output.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115_200,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_start,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 tx
);

    localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int IDX_W        = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_baud
            $error("uart_tx: CLK_FREQ / BAUD_RATE must be at least 2");
        end
    endgenerate

    state_t               state, state_next;
    logic [IDX_W-1:0]     idx, idx_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic                 tx_q, tx_next;
    logic                 done_next;
    logic                 bit_tick;
    logic                 baud_clear;

    // The bit timer only runs while a frame is in flight, so the first START cycle sees count 0.
    assign baud_clear = (state == ST_IDLE);

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (baud_clear),
        .bit_tick(bit_tick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            idx       <= '0;
            // NOTE: the data latch is cleared on reset too, so no frame ever carries stale bits.
            shift_reg <= '0;
            tx_q      <= IDLE_LEVEL;
        end else begin
            state     <= state_next;
            idx       <= idx_next;
            shift_reg <= shift_next;
            tx_q      <= tx_next;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_next = state;
        idx_next   = idx;
        shift_next = shift_reg;
        tx_next    = tx_q;
        done_next  = 1'b0;

        case (state)
            ST_IDLE: begin
                tx_next = IDLE_LEVEL;
                if (tx_start) begin
                    state_next = ST_START;
                    shift_next = tx_data;
                    idx_next   = '0;
                    tx_next    = ~IDLE_LEVEL;
                end
            end

            ST_START: begin
                if (bit_tick) begin
                    state_next = ST_DATA;
                    idx_next   = '0;
                    tx_next    = shift_reg[0];
                end
            end

            ST_DATA: begin
                if (bit_tick) begin
                    if (idx == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_next = ST_PARITY;
                        tx_next    = ^shift_reg;
`else
                        state_next = ST_STOP;
                        tx_next    = IDLE_LEVEL;
`endif
                    end else begin
                        idx_next = idx + 1'b1;
                        tx_next  = shift_reg[idx + 1'b1];
                    end
                end
            end

`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_tick) begin
                    state_next = ST_STOP;
                    tx_next    = IDLE_LEVEL;
                end
            end
`endif

            ST_STOP: begin
                if (bit_tick) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                    tx_next    = IDLE_LEVEL;
                end
            end

            default: begin
                state_next = ST_IDLE;
                tx_next    = IDLE_LEVEL;
            end
        endcase
    end

    assign tx      = tx_q;
    assign tx_busy = (state != ST_IDLE);
    assign tx_done = done_next;

endmodule
